// File: rtl/sdpb_sample_writer_pkg.sv
// Purpose : shared constants, FSM state type and helpers for the sample buffer writer.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package sdpb_sample_writer_pkg;

   localparam int SAMPLES_PER_LINE = 4;
   localparam int LINES            = 32;
   localparam int HALF_LINES       = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   // One-hot mask selecting a ping-pong half.
   function automatic logic [1:0] half_mask(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sdpb_lane_packer.sv
// Purpose : collects SAMPLES_PER_LINE samples into one line, first sample in the low lane.
// Latency : line_valid/line_data registered, one cycle after the last sample of a line is pushed.
// Backpr. : none; the caller only pushes when it can take the line.
// Ports   : clk, reset (sync, high), flush (drop partial line), push/sample (sample in),
//           line_end (comb: this push completes a line), line_valid/line_data (registered line out).
module sdpb_lane_packer
   import sdpb_sample_writer_pkg::*;
#(
   parameter int SAMPLE_W = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 flush,
   input  logic                                 push,
   input  logic [SAMPLE_W-1:0]                  sample,
   output logic                                 line_end,
   output logic                                 line_valid,
   output logic [SAMPLES_PER_LINE*SAMPLE_W-1:0] line_data
);

   localparam int LANE_W = $clog2(SAMPLES_PER_LINE);

   logic [LANE_W-1:0]                       lane;
   // Holds all lanes but the last; the last sample goes straight into line_data.
   logic [(SAMPLES_PER_LINE-1)*SAMPLE_W-1:0] hold;

   assign line_end = push & (lane == LANE_W'(SAMPLES_PER_LINE - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         lane       <= '0;
         hold       <= '0;
         line_valid <= 1'b0;
         line_data  <= '0;
      end else if (flush) begin
         lane       <= '0;
         hold       <= '0;
         line_valid <= 1'b0;
      end else begin
         line_valid <= line_end;
         if (line_end) begin
            line_data <= {sample, hold};
            lane      <= '0;
         end else if (push) begin
            for (int k = 0; k < SAMPLES_PER_LINE - 1; k++) begin
               if (lane == LANE_W'(k)) hold[k*SAMPLE_W +: SAMPLE_W] <= sample;
            end
            lane <= lane + LANE_W'(1);
         end
      end
   end

endmodule

// File: rtl/sdpb_sample_writer.sv
// Purpose : packs 16b samples into 64b lines and writes them into a 32-line ping-pong buffer.
// Latency : line write (wr_ce) one cycle after the 4th sample of the line is accepted.
// Backpr. : s_ready drops while the next half is still full, unless DROP_ON_FULL (then discard + overflow).
// Ports   : clk/reset (sync, high), enable (low = flush), s_valid/s_data/s_ready (sample stream),
//           wr_ce/wr_addr/wr_data (buffer write port), half_done/half_id (half filled pulse),
//           half_ack/half_ack_id (reader release), half_full (per-half flags), overflow (sticky drop).
module sdpb_sample_writer
   import sdpb_sample_writer_pkg::*;
#(
   parameter int SAMPLE_W     = 16,
   parameter int ADDR_W       = $clog2(LINES),
   parameter int DROP_ON_FULL = 0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic                                 s_valid,
   input  logic [SAMPLE_W-1:0]                  s_data,
   output logic                                 s_ready,
   output logic                                 wr_ce,
   output logic [ADDR_W-1:0]                    wr_addr,
   output logic [SAMPLES_PER_LINE*SAMPLE_W-1:0] wr_data,
   output logic                                 half_done,
   output logic                                 half_id,
   input  logic                                 half_ack,
   input  logic                                 half_ack_id,
   output logic [1:0]                           half_full,
   output logic                                 overflow
);

   localparam int HALF_W = $clog2(HALF_LINES);

   state_t                                 state_q, state_d;
   logic [ADDR_W-1:0]                      line_q;
   logic [ADDR_W-1:0]                      wr_addr_q;
   logic [1:0]                             half_full_q, hf_next, set_mask, ack_mask;
   logic                                   half_done_q, half_id_q, overflow_q;
   logic                                   push, drop, line_end, line_valid, cur_half, half_last;
   logic [SAMPLES_PER_LINE*SAMPLE_W-1:0]   line_data;

   // Ready depends on state only, never on s_valid.
   assign s_ready = (state_q == ST_RUN) | ((DROP_ON_FULL != 0) && (state_q == ST_STALL));

   assign push = s_valid & s_ready & enable & (state_q == ST_RUN);
   assign drop = s_valid & s_ready & enable & (state_q == ST_STALL);

   // The top address bit names the half; a half ends on its last in-half line.
   assign cur_half  = line_q[ADDR_W-1];
   assign half_last = &line_q[HALF_W-1:0];

   assign set_mask = (line_end & half_last) ? half_mask(cur_half) : 2'b00;
   assign ack_mask = half_ack ? half_mask(half_ack_id) : 2'b00;
   // Acks to an empty half are harmless; a same-cycle set on that half wins.
   assign hf_next  = (half_full_q & ~ack_mask) | set_mask;

   sdpb_lane_packer #(
      .SAMPLE_W (SAMPLE_W)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .flush      (~enable),
      .push       (push),
      .sample     (s_data),
      .line_end   (line_end),
      .line_valid (line_valid),
      .line_data  (line_data)
   );

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (!half_full_q[0]) state_d = ST_RUN;
            // Stall when the half just completed leaves no free half to move into.
            ST_RUN:   if ((set_mask != 2'b00) && hf_next[~cur_half]) state_d = ST_STALL;
            // line_q already points at the first line of the half being waited for.
            ST_STALL: if (half_ack && (half_ack_id == cur_half)) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         line_q      <= '0;
         wr_addr_q   <= '0;
         half_full_q <= 2'b00;
         half_done_q <= 1'b0;
         half_id_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (!enable) begin
            line_q      <= '0;
            wr_addr_q   <= '0;
            half_full_q <= 2'b00;
            half_done_q <= 1'b0;
            half_id_q   <= 1'b0;
            overflow_q  <= 1'b0;
         end else begin
            half_full_q <= hf_next;
            half_done_q <= (set_mask != 2'b00);
            if (set_mask != 2'b00) half_id_q <= cur_half;
            if (line_end) begin
               wr_addr_q <= line_q;
               line_q    <= line_q + ADDR_W'(1);
            end
            if (drop) overflow_q <= 1'b1;
         end
      end
   end

   // A line queued for writing must not reach the buffer while reset is asserted.
   assign wr_ce     = line_valid & ~reset;
   assign half_done = half_done_q & ~reset;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = line_data;
   assign half_id   = half_id_q;
   assign half_full = half_full_q;
   assign overflow  = overflow_q;

endmodule
